iob_parking_sensor: RTL

Parking-spot sensor front end that sits directly upstream of the SoC `SENSOR_IN` consumer. It takes the 32 raw spot-sensor lines from the lot, synchronises and debounces each line independently, and maintains a stable occupancy bitmap, an occupied-spot count and sticky per-spot change flags. Firmware reads these through a native IOb-style register port, and an optional interrupt can be compiled in.

---
 rtl/iob_parking_sensor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/iob_parking_sensor.sv
// iob_parking_sensor: per-spot 2-flop sync + debounce, occupancy bitmap/count, sticky change flags, IOb register port.
// Optional change interrupt: define PARKING_SENSOR_IRQ_EN.
module iob_parking_spot #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_bit,
  input  logic [DEBOUNCE_W-1:0] thr,
  output logic                  stable,
  output logic                  change_set
);
  logic [DEBOUNCE_W-1:0] cnt;
  logic [DEBOUNCE_W:0]   cnt_inc;

  // Extra carry bit lets the counter saturate instead of wrapping.
  assign cnt_inc    = {1'b0, cnt} + (DEBOUNCE_W+1)'(1);
  assign change_set = (sync_bit != stable) && (cnt_inc >= {1'b0, thr});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_bit == stable) begin
      cnt <= '0;
    end else if (change_set) begin
      stable <= ~stable;
      cnt    <= '0;
    end else if (!cnt_inc[DEBOUNCE_W]) begin
      cnt <= cnt_inc[DEBOUNCE_W-1:0];
    end
  end
endmodule

module iob_parking_sensor #(
  parameter int N_SPOTS      = 32,
  parameter int DEBOUNCE_W   = 16,
  parameter int DEBOUNCE_RST = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SPOTS-1:0] sensor_in,
  input  logic               valid,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic [31:0]        rdata,
  output logic               ready
`ifdef PARKING_SENSOR_IRQ_EN
  ,
  output logic               irq
`endif
);
  localparam logic [1:0] A_STATUS = 2'd0, A_COUNT = 2'd1, A_CHANGE = 2'd2, A_DEB = 2'd3;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } req_t;

  req_t                  req;
  logic [N_SPOTS-1:0]    sync1, sync2, stable, change_set, change;
  logic [5:0]            count, pop;
  logic [DEBOUNCE_W-1:0] debounce, thr, deb_merge;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign req.rd       = valid && (wstrb == 4'd0);
  assign req.wr       = valid && (wstrb != 4'd0);
  assign req.addr     = addr;
  assign unused_wdata = ^wdata;

  assign thr = (debounce == '0) ? DEBOUNCE_W'(1) : debounce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_SPOTS; g++) begin : g_spot
    iob_parking_spot #(.DEBOUNCE_W(DEBOUNCE_W)) u_spot (
      .clk       (clk),
      .rst       (rst),
      .sync_bit  (sync2[g]),
      .thr       (thr),
      .stable    (stable[g]),
      .change_set(change_set[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SPOTS; i++) pop = pop + 6'(stable[i]);
  end

  always_comb begin
    deb_merge = debounce;
    for (int i = 0; i < DEBOUNCE_W; i++)
      if (wstrb[i/8]) deb_merge[i] = wdata[i];
  end

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      A_STATUS: rd_mux = 32'(stable);
      A_COUNT:  rd_mux = 32'(count);
      A_CHANGE: rd_mux = 32'(change);
      default:  rd_mux = 32'(debounce);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      change   <= '0;
      debounce <= DEBOUNCE_W'(DEBOUNCE_RST);
      rdata    <= '0;
      ready    <= 1'b0;
    end else begin
      count <= pop;
      ready <= valid;
      // New changes landing on the clearing edge survive the clear.
      if (req.rd && req.addr == A_CHANGE) change <= change_set;
      else                                change <= change | change_set;
      if (req.rd) rdata <= rd_mux;
      if (req.wr && req.addr == A_DEB) debounce <= deb_merge;
    end
  end

`ifdef PARKING_SENSOR_IRQ_EN
  logic [N_SPOTS-1:0] stable_mask;
  assign stable_mask = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |(change & stable_mask);
  end
`endif
endmodule
